ecc_dec_seq: RTL

ECC_DEC_SEQ -- requirements
Module: ecc_dec_seq

---
 rtl/ecc_pkg.sv | 33 +++
 rtl/secded_dec.sv | 54 +++++
 rtl/ecc_dec_seq.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ecc_pkg.sv
// ecc_pkg -- shared types and constants for the SECDED decode sequencer.
//   state_t      : sequencer states
//   CLS_*        : decode classification codes (also the result flag field)
//   DEF_*        : default word count and memory base addresses
//   extract_data : pulls d[11:1] out of a 16-bit codeword
package ecc_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RD_LO = 3'd1,
      S_RD_HI = 3'd2,
      S_WR_LO = 3'd3,
      S_WR_HI = 3'd4,
      S_FIN   = 3'd5
   } state_t;

   localparam logic [1:0] CLS_NONE = 2'b00;
   localparam logic [1:0] CLS_SGL  = 2'b01;
   localparam logic [1:0] CLS_DBL  = 2'b10;

   localparam int DEF_NUM_WORDS = 15;
   localparam int DEF_SRC_BASE  = 30;
   localparam int DEF_DST_BASE  = 0;

   // Result word reported for an uncorrectable (double) error.
   localparam logic [15:0] RES_DBL = 16'h8000;

   // Data bits d1..d11 sit at codeword positions 3,5,6,7,9..15 (d1 is the LSB).
   function automatic logic [10:0] extract_data(input logic [15:0] cw);
      return {cw[15:9], cw[7:5], cw[3]};
   endfunction

endpackage

// File: rtl/secded_dec.sv
// secded_dec -- combinational extended-Hamming (16,11) decoder.
//   cw  : codeword; bit0 = overall parity, bits 1,2,4,8 = Hamming parity
//   res : {class[1:0], 3'b0, d[11:1]} for none/single, 16'h8000 for double
//   cls : CLS_NONE / CLS_SGL / CLS_DBL
module secded_dec
   import ecc_pkg::*;
(
   input  logic [15:0] cw,
   output logic [15:0] res,
   output logic [1:0]  cls
);

   // Each set bit k contributes its own index to the syndrome.
   logic [3:0]  term [16];
   logic [3:0]  syn;
   logic        par;
   logic [15:0] fixed;

   assign term[0] = 4'd0;

   genvar gi;
   generate
      for (gi = 1; gi < 16; gi++) begin : g_term
         assign term[gi] = cw[gi] ? 4'(gi) : 4'd0;
      end
   endgenerate

   always_comb begin
      syn = 4'd0;
      for (int k = 0; k < 16; k++) begin
         syn = syn ^ term[k];
      end
      par = ^cw;

      // Odd overall parity means one flipped bit at position syn; syn==0
      // points at p0 itself, which leaves the data untouched.
      fixed = cw;
      if (par) begin
         fixed = cw ^ (16'd1 << syn);
      end

      if (par) begin
         cls = CLS_SGL;
         res = {CLS_SGL, 3'b000, extract_data(fixed)};
      end else if (syn == 4'd0) begin
         cls = CLS_NONE;
         res = {CLS_NONE, 3'b000, extract_data(cw)};
      end else begin
         cls = CLS_DBL;
         res = RES_DBL;
      end
   end

endmodule

// File: rtl/ecc_dec_seq.sv
// ecc_dec_seq -- walks NUM_WORDS codewords in byte memory, decodes each one
// and writes the 16-bit result back, counting single/double errors.
//   clk, reset : clock and synchronous active-high reset
//   start      : run request, only looked at in IDLE
//   done       : run finished; stays high until the next accepted start
//   mem_addr   : byte address (0 when memory is idle)
//   mem_rdata  : read data, combinational from mem_addr
//   mem_we     : write strobe, memory writes on the clock edge
//   mem_wdata  : write data (0 when not writing)
//   err1_cnt   : single-error codewords in last run (saturates at 15)
//   err2_cnt   : double-error codewords in last run (saturates at 15)
module ecc_dec_seq
   import ecc_pkg::*;
#(
   parameter int NUM_WORDS = DEF_NUM_WORDS,
   parameter int SRC_BASE  = DEF_SRC_BASE,
   parameter int DST_BASE  = DEF_DST_BASE
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       done,
   output logic [7:0] mem_addr,
   input  logic [7:0] mem_rdata,
   output logic       mem_we,
   output logic [7:0] mem_wdata,
   output logic [3:0] err1_cnt,
   output logic [3:0] err2_cnt
);

   state_t      state_reg;
   state_t      state_next;
   logic [6:0]  idx_reg;
   logic [15:0] cw_reg;
   logic        done_reg;
   logic [3:0]  err1_reg;
   logic [3:0]  err2_reg;

   logic [15:0] res;
   logic [1:0]  cls;
   logic [7:0]  src_addr;
   logic [7:0]  dst_addr;
   logic        last_word;

   secded_dec u_dec (
      .cw  (cw_reg),
      .res (res),
      .cls (cls)
   );

   assign src_addr  = 8'(SRC_BASE) + {idx_reg, 1'b0};
   assign dst_addr  = 8'(DST_BASE) + {idx_reg, 1'b0};
   assign last_word = (idx_reg == 7'(NUM_WORDS - 1));

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (start) state_next = S_RD_LO;
         S_RD_LO: state_next = S_RD_HI;
         S_RD_HI: state_next = S_WR_LO;
         S_WR_LO: state_next = S_WR_HI;
         S_WR_HI: state_next = last_word ? S_FIN : S_RD_LO;
         S_FIN:   state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Memory-port outputs. Gated by reset so that a reset arriving while
   // sitting in a write state cannot sneak one last byte into memory.
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = 8'd0;
      mem_wdata = 8'd0;
      if (!reset) begin
         case (state_reg)
            S_RD_LO: mem_addr = src_addr;
            S_RD_HI: mem_addr = src_addr + 8'd1;
            S_WR_LO: begin
               mem_we    = 1'b1;
               mem_addr  = dst_addr;
               mem_wdata = res[7:0];
            end
            S_WR_HI: begin
               mem_we    = 1'b1;
               mem_addr  = dst_addr + 8'd1;
               mem_wdata = res[15:8];
            end
            default: ;
         endcase
      end
   end

   // Datapath: word index, codeword capture, done flag and error counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         idx_reg  <= 7'd0;
         cw_reg   <= 16'd0;
         done_reg <= 1'b0;
         err1_reg <= 4'd0;
         err2_reg <= 4'd0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  idx_reg  <= 7'd0;
                  done_reg <= 1'b0;
                  err1_reg <= 4'd0;
                  err2_reg <= 4'd0;
               end
            end
            S_RD_LO: cw_reg[7:0]  <= mem_rdata;
            S_RD_HI: cw_reg[15:8] <= mem_rdata;
            S_WR_HI: begin
               if (cls == CLS_SGL && err1_reg != 4'hF) begin
                  err1_reg <= err1_reg + 4'd1;
               end
               if (cls == CLS_DBL && err2_reg != 4'hF) begin
                  err2_reg <= err2_reg + 4'd1;
               end
               if (!last_word) begin
                  idx_reg <= idx_reg + 7'd1;
               end
            end
            S_FIN: done_reg <= 1'b1;
            default: ;
         endcase
      end
   end

   assign done     = done_reg;
   assign err1_cnt = err1_reg;
   assign err2_cnt = err2_reg;

endmodule
